// File: rtl/uart_mmio_tx_bridge_if.sv
// CPU data-port request/response signals and UART sink stream for uart_mmio_tx_bridge.
interface uart_mmio_tx_bridge_if;
   logic [31:0] Address;
   logic        MemWrite;
   logic [31:0] Write_data;
   logic [3:0]  Write_strb;
   logic        MemRead;
   logic        Mem_Req_Ready;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready;
   logic        hit;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready, tx_ready,
      input  Mem_Req_Ready, Read_data, Read_data_Valid, hit, tx_data, tx_valid
   );

   modport slave (
      input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready, tx_ready,
      output Mem_Req_Ready, Read_data, Read_data_Valid, hit, tx_data, tx_valid
   );
endinterface

// File: rtl/uart_mmio_tx_bridge.sv
// Memory-mapped UART transmit slave: TXDATA FIFO, STATUS/CTRL registers, valid/ready drain.
// Optional UART_TX_DROP_ON_FULL_EN: accept-and-drop TXDATA writes while full, sticky overflow.
module uart_mmio_tx_bridge #(
   parameter logic [15:0] BASE_HI = 16'h6000,
   parameter int          DEPTH   = 16
) (
   input  logic                 cpu_clk,
   input  logic                 cpu_reset_n,
   uart_mmio_tx_bridge_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, RESP} state_t;
   state_t state, state_nxt;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [31:0]   rdata, reg_val;
   logic [3:0]    off;
   logic          empty, full, push_req, push, pop, flush;
   logic          rd_acc, wr_acc, req_ready;
   logic          unused_bits;

   assign off       = bus.Address[3:0];
   assign bus.hit   = bus.Address[31:16] == BASE_HI;
   assign empty     = count == '0;
   assign full      = count == CW'(DEPTH);
   assign push_req  = (off == 4'h4) & bus.Write_strb[0];
   assign unused_bits = ^{bus.Address[15:4], bus.Write_data[31:8], bus.Write_strb[3:1]};

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rd_acc    = 1'b0;
      wr_acc    = 1'b0;
      case (state)
         IDLE: if (bus.hit) begin
            if (bus.MemRead) begin
               req_ready = 1'b1;
               rd_acc    = 1'b1;
               state_nxt = RESP;
            end else if (bus.MemWrite) begin
`ifdef UART_TX_DROP_ON_FULL_EN
               req_ready = 1'b1;
`else
               // full is registered state: a same-cycle pop never unblocks the write
               req_ready = ~(push_req & full);
`endif
               wr_acc = req_ready;
            end
         end
         RESP: if (bus.Read_data_Ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.Mem_Req_Ready   = req_ready;
   assign bus.Read_data_Valid = state == RESP;
   assign bus.Read_data       = rdata;

   assign push  = wr_acc & push_req & ~full;
   assign flush = wr_acc & (off == 4'hC) & bus.Write_data[0];
   assign pop   = ~empty & bus.tx_ready;

   always_comb begin
      reg_val = '0;
      if (off == 4'h8) reg_val = {16'h0, 8'(count), 5'h0, overflow, full, empty};
   end

   always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         state <= IDLE;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         if (rd_acc) rdata <= reg_val;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push & ~pop)      count <= count + CW'(1);
         else if (pop & ~push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge cpu_clk)
      if (push) mem[wr_ptr] <= bus.Write_data[7:0];

   assign bus.tx_valid = ~empty;
   assign bus.tx_data  = empty ? 8'h00 : mem[rd_ptr];

`ifdef UART_TX_DROP_ON_FULL_EN
   always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n)                    overflow <= 1'b0;
      else if (flush)                      overflow <= 1'b0;
      else if (wr_acc & push_req & full)   overflow <= 1'b1;
   end
`else
   assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_mmio_tx_bridge.sv
// Directed bench for uart_mmio_tx_bridge with a queue-based reference model checked every cycle.
module tb_uart_mmio_tx_bridge;
   localparam int DEPTH = 16;
   localparam logic [31:0] TXD  = 32'h6000_0004;
   localparam logic [31:0] STAT = 32'h6000_0008;
   localparam logic [31:0] CTRL = 32'h6000_000C;
`ifdef UART_TX_DROP_ON_FULL_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic cpu_clk = 1'b0;
   logic cpu_reset_n = 1'b0;
   uart_mmio_tx_bridge_if bus();

   uart_mmio_tx_bridge #(.BASE_HI(16'h6000), .DEPTH(DEPTH)) dut (
      .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n), .bus(bus));

   always #5 cpu_clk = ~cpu_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // reference model: byte queue, sticky overflow, pending read response
   logic [7:0]  q[$];
   bit          m_ovf, m_pend;
   logic [31:0] m_rdata;
   bit          m_acc, m_pop, m_push, m_flush;
   logic [3:0]  m_off;

   function automatic logic [31:0] status_val();
      return (32'(q.size()) << 8) | (m_ovf ? 32'h4 : 32'h0) |
             ((q.size() == DEPTH) ? 32'h2 : 32'h0) | ((q.size() == 0) ? 32'h1 : 32'h0);
   endfunction

   function automatic bit m_ready();
      if (m_pend || bus.Address[31:16] != 16'h6000) return 1'b0;
      if (bus.MemRead) return 1'b1;
      if (!bus.MemWrite) return 1'b0;
      return !(!DROP && bus.Address[3:0] == 4'h4 && bus.Write_strb[0] && q.size() == DEPTH);
   endfunction

   always @(posedge cpu_clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         q.delete();
         m_ovf = 1'b0; m_pend = 1'b0; m_rdata = '0;
      end else begin
         m_acc = m_ready();
         m_off = bus.Address[3:0];
         m_pop = q.size() != 0 && bus.tx_ready;
         m_push = 1'b0; m_flush = 1'b0;
         if (m_pend) begin
            if (bus.Read_data_Ready) m_pend = 1'b0;
         end else if (m_acc && bus.MemRead) begin
            m_rdata = (m_off == 4'h8) ? status_val() : 32'h0;
            m_pend = 1'b1;
         end else if (m_acc) begin
            if (m_off == 4'h4 && bus.Write_strb[0]) begin
               if (q.size() < DEPTH) m_push = 1'b1;
               else m_ovf = 1'b1;
            end
            if (m_off == 4'hC && bus.Write_data[0]) m_flush = 1'b1;
         end
         if (m_flush) begin
            q.delete();
            m_ovf = 1'b0;
         end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(bus.Write_data[7:0]);
         end
      end
   end

   always @(negedge cpu_clk) begin
      chk("hit", {31'h0, bus.hit}, {31'h0, bus.Address[31:16] == 16'h6000});
      chk("req_ready", {31'h0, bus.Mem_Req_Ready}, {31'h0, m_ready()});
      chk("rd_valid", {31'h0, bus.Read_data_Valid}, {31'h0, m_pend});
      chk("rd_data", bus.Read_data, m_rdata);
      chk("tx_valid", {31'h0, bus.tx_valid}, {31'h0, q.size() != 0});
      if (q.size() != 0) chk("tx_data", {24'h0, bus.tx_data}, {24'h0, q[0]});
      else if (!cpu_reset_n) chk("tx_data_rst", {24'h0, bus.tx_data}, 32'h0);
   end

   logic [7:0] sink[$];
   int         sink_cyc[$];
   int         cyc = 0;
   always @(posedge cpu_clk) cyc++;
   always @(negedge cpu_clk)
      if (cpu_reset_n && bus.tx_valid && bus.tx_ready) begin
         sink.push_back(bus.tx_data);
         sink_cyc.push_back(cyc);
      end

   task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output int waits);
      bus.Address = addr; bus.Write_data = data; bus.Write_strb = strb; bus.MemWrite = 1'b1;
      waits = 0;
      forever begin
         @(negedge cpu_clk);
         if (bus.Mem_Req_Ready) break;
         waits++;
         if (waits == 200) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h", addr);
            break;
         end
      end
      @(posedge cpu_clk); #1;
      bus.MemWrite = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      int w;
      cpu_write(addr, data, 4'h1, w);
   endtask

   task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
      int n;
      bus.Address = addr; bus.MemRead = 1'b1;
      n = 0;
      forever begin
         @(negedge cpu_clk);
         if (bus.Mem_Req_Ready) break;
         n++;
         if (n == 200) begin
            checks++; errors++;
            $display("FAIL read_req_timeout addr=%h", addr);
            break;
         end
      end
      @(posedge cpu_clk); #1;
      bus.MemRead = 1'b0;
      n = 0;
      forever begin
         @(negedge cpu_clk);
         if (bus.Read_data_Valid) break;
         n++;
         if (n == 200) begin
            checks++; errors++;
            $display("FAIL read_resp_timeout addr=%h", addr);
            break;
         end
      end
      data = bus.Read_data;
      @(posedge cpu_clk); #1;
   endtask

   initial begin
      logic [31:0] d;
      int w;
      bus.Address = '0; bus.MemWrite = 1'b0; bus.Write_data = '0; bus.Write_strb = '0;
      bus.MemRead = 1'b0; bus.Read_data_Ready = 1'b1; bus.tx_ready = 1'b0;
      repeat (2) @(posedge cpu_clk);
      #1;
      chk("rst_rd_valid", {31'h0, bus.Read_data_Valid}, 32'h0);
      chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      cpu_reset_n = 1'b1;
      @(posedge cpu_clk); #1;

      cpu_read(STAT, d);
      chk("status_reset", d, 32'h0000_0001);

      wr(TXD, 32'h41);
      wr(TXD, 32'h42);
      cpu_read(STAT, d);
      chk("status_two", d, 32'h0000_0200);
      sink.delete(); sink_cyc.delete();
      bus.tx_ready = 1'b1;
      repeat (3) @(posedge cpu_clk);
      #1;
      chk("sink_count", sink.size(), 2);
      if (sink.size() == 2) begin
         chk("sink0", {24'h0, sink[0]}, 32'h41);
         chk("sink1", {24'h0, sink[1]}, 32'h42);
         chk("sink_consecutive", sink_cyc[1] - sink_cyc[0], 1);
      end
      cpu_read(STAT, d);
      chk("status_drained", d, 32'h0000_0001);

      bus.tx_ready = 1'b0;
      sink.delete(); sink_cyc.delete();
      for (int i = 0; i < 16; i++) wr(TXD, i);
      cpu_read(STAT, d);
      chk("status_full", d, 32'h0000_1002);
`ifdef UART_TX_DROP_ON_FULL_EN
      cpu_write(TXD, 32'd16, 4'h1, w);
      chk("drop_no_stall", w, 0);
      cpu_read(STAT, d);
      chk("status_overflow", d, 32'h0000_1006);
      wr(CTRL, 32'h1);
      cpu_read(STAT, d);
      chk("status_flushed", d, 32'h0000_0001);
`else
      fork
         cpu_write(TXD, 32'd16, 4'h1, w);
         begin
            repeat (3) @(posedge cpu_clk);
            #1 bus.tx_ready = 1'b1;
            @(posedge cpu_clk);
            #1 bus.tx_ready = 1'b0;
         end
      join
      chk("stall_cycles", w, 4);
      bus.tx_ready = 1'b1;
      repeat (20) @(posedge cpu_clk);
      #1;
      chk("drain_count", sink.size(), 17);
      for (int i = 0; i < 17 && i < sink.size(); i++) chk("drain_byte", {24'h0, sink[i]}, i);
`endif

      bus.tx_ready = 1'b0;
      bus.Read_data_Ready = 1'b0;
      cpu_read(STAT, d);
      chk("hold_status", d, 32'h0000_0001);
      bus.Address = TXD; bus.Write_data = 32'h77; bus.Write_strb = 4'h1; bus.MemWrite = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge cpu_clk);
         chk("hold_valid", {31'h0, bus.Read_data_Valid}, 32'h1);
         chk("hold_data", bus.Read_data, 32'h0000_0001);
         chk("hold_req_ready", {31'h0, bus.Mem_Req_Ready}, 32'h0);
      end
      @(posedge cpu_clk); #1;
      bus.MemWrite = 1'b0;
      bus.Read_data_Ready = 1'b1;
      @(posedge cpu_clk); #1;
      chk("release_valid", {31'h0, bus.Read_data_Valid}, 32'h0);
      cpu_read(STAT, d);
      chk("hold_write_dropped", d, 32'h0000_0001);

      bus.Address = 32'h5000_0004; bus.Write_data = 32'h55; bus.Write_strb = 4'h1; bus.MemWrite = 1'b1;
      @(negedge cpu_clk);
      chk("miss_hit", {31'h0, bus.hit}, 32'h0);
      chk("miss_req_ready", {31'h0, bus.Mem_Req_Ready}, 32'h0);
      @(posedge cpu_clk); #1;
      bus.MemWrite = 1'b0;
      chk("miss_tx_valid", {31'h0, bus.tx_valid}, 32'h0);

      wr(TXD, 32'hA1);
      wr(TXD, 32'hA2);
      wr(TXD, 32'hA3);
      chk("pre_flush_valid", {31'h0, bus.tx_valid}, 32'h1);
      wr(CTRL, 32'h1);
      chk("flush_tx_valid", {31'h0, bus.tx_valid}, 32'h0);

      for (int i = 0; i < 4; i++) wr(TXD, 32'hB0 + i);
      bus.Read_data_Ready = 1'b0;
      cpu_read(STAT, d);
      chk("status_four", d, 32'h0000_0400);
      #3 cpu_reset_n = 1'b0;
      #1;
      chk("rst_mid_rd_valid", {31'h0, bus.Read_data_Valid}, 32'h0);
      chk("rst_mid_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      @(posedge cpu_clk); #1;
      cpu_reset_n = 1'b1;
      bus.Read_data_Ready = 1'b1;
      @(posedge cpu_clk); #1;
      cpu_read(STAT, d);
      chk("status_after_rst", d, 32'h0000_0001);

      repeat (2) @(posedge cpu_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
